// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants and the scoreboard latency-width helper.
package cpu_pkg;

    localparam int unsigned DEF_REG_AW   = 4;
    localparam int unsigned DEF_LOAD_LAT = 1;
    localparam int unsigned DEF_ALU_LAT  = 0;

    // Counter width able to hold max(load_lat, alu_lat); never narrower than one bit.
    function automatic int unsigned lat_width(input int unsigned load_lat,
                                              input int unsigned alu_lat);
        int unsigned max_lat;
        max_lat = (load_lat > alu_lat) ? load_lat : alu_lat;
        return (max_lat == 0) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard handshake: instruction descriptor in, issue/stall decisions and status out.
interface hazard_scoreboard_if
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned CNT_W  = 16
) ();

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_is_load;
    logic              id_halt;
    logic              flush;
    logic              mem_stall;
    logic              stall;
    logic              issue;
    logic              bubble;
    logic              halted;
    logic              drained;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_reg_write,
               id_is_load, id_halt, flush, mem_stall,
        input  stall, issue, bubble, halted, drained, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_reg_write,
               id_is_load, id_halt, flush, mem_stall,
        output stall, issue, bubble, halted, drained, stall_count
    );

endinterface

// File: rtl/sb_entry.sv
// One register's pending-write countdown; busy while the count is nonzero.
module sb_entry #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         freeze,
    output logic         busy
);

    logic [W-1:0] cnt_q, cnt_d;

    // A new producer overrides any countdown in flight, even with a shorter latency.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!freeze && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard deciding issue/stall/bubble for the instruction in ID.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_AW   = DEF_REG_AW,
    parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
    parameter int unsigned ALU_LAT  = DEF_ALU_LAT,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned CNT_W    = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    hazard_scoreboard_if.slave  sb
);

    localparam int unsigned LW = lat_width(LOAD_LAT, ALU_LAT);

    if (LOAD_LAT < ALU_LAT || NUM_REGS != 2 ** REG_AW) begin : g_param_check
        $error("hazard_scoreboard: need LOAD_LAT >= ALU_LAT and NUM_REGS == 2**REG_AW");
    end

    logic [NUM_REGS-1:0] busy;
    logic [LW-1:0]       load_val;
    logic                rs_busy, rt_busy, hazard, issue, do_write;
    logic                halted_q, halted_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    always_comb begin
        rs_busy  = sb.id_rs_used && busy[sb.id_rs] && !(ZERO_REG != 0 && sb.id_rs == '0);
        rt_busy  = sb.id_rt_used && busy[sb.id_rt] && !(ZERO_REG != 0 && sb.id_rt == '0);
        hazard   = sb.id_valid && (rs_busy || rt_busy);
        issue    = sb.id_valid && !hazard && !sb.flush && !sb.mem_stall && !halted_q;
        do_write = issue && sb.id_reg_write && !(ZERO_REG != 0 && sb.id_rd == '0);
        load_val = sb.id_is_load ? LW'(LOAD_LAT) : LW'(ALU_LAT);

        halted_d = halted_q;
        if (issue && sb.id_halt) begin
            halted_d = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (hazard && !sb.flush && !sb.mem_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        sb_entry #(
            .W (LW)
        ) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (do_write && (sb.id_rd == REG_AW'(i))),
            .load_val (load_val),
            .freeze   (sb.mem_stall),
            .busy     (busy[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sb.issue       = issue;
    assign sb.stall       = sb.mem_stall || (hazard && !sb.flush) ||
                            (halted_q && sb.id_valid && !sb.flush);
    assign sb.bubble      = !issue && !sb.mem_stall;
    assign sb.halted      = halted_q;
    assign sb.drained     = halted_q && (busy == '0);
    assign sb.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven check of hazard_scoreboard: default build (A) and a long-latency, narrow-counter build (B).
module tb_hazard_scoreboard;

    logic clk;
    logic rst_n;

    hazard_scoreboard_if #(.REG_AW(4), .CNT_W(16)) bus_a ();
    hazard_scoreboard_if #(.REG_AW(4), .CNT_W(2))  bus_b ();

    hazard_scoreboard #(
        .NUM_REGS (16), .REG_AW (4), .LOAD_LAT (1), .ALU_LAT (0), .ZERO_REG (1), .CNT_W (16)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus_a)
    );

    hazard_scoreboard #(
        .NUM_REGS (16), .REG_AW (4), .LOAD_LAT (3), .ALU_LAT (1), .ZERO_REG (1), .CNT_W (2)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit [8*8-1:0] name;
        bit           dut;
        bit           rst;
        bit           valid;
        bit [3:0]     rs;
        bit           rs_used;
        bit [3:0]     rt;
        bit           rt_used;
        bit [3:0]     rd;
        bit           rw;
        bit           ld;
        bit           hlt;
        bit           fl;
        bit           ms;
        bit [4:0]     exp_flags;  // {stall, issue, bubble, halted, drained}
        int           exp_cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    function automatic vec_t mk(input bit [8*8-1:0] name, input bit dut, input bit rst,
                                input bit valid, input bit [3:0] rs, input bit rsu,
                                input bit [3:0] rt, input bit rtu, input bit [3:0] rd,
                                input bit rw, input bit ld, input bit hlt, input bit fl,
                                input bit ms, input bit [4:0] flags, input int cnt);
        vec_t v;
        v.name = name; v.dut = dut; v.rst = rst; v.valid = valid;
        v.rs = rs; v.rs_used = rsu; v.rt = rt; v.rt_used = rtu; v.rd = rd;
        v.rw = rw; v.ld = ld; v.hlt = hlt; v.fl = fl; v.ms = ms;
        v.exp_flags = flags; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        vec_t       e;
        logic [4:0] got_flags;
        int         got_cnt;
        @(posedge clk);
        #1;
        bus_a.id_valid = v.valid && !v.dut;  bus_b.id_valid = v.valid && v.dut;
        bus_a.mem_stall = v.ms && !v.dut;    bus_b.mem_stall = v.ms && v.dut;
        bus_a.flush = v.fl;         bus_b.flush = v.fl;
        bus_a.id_rs = v.rs;         bus_b.id_rs = v.rs;
        bus_a.id_rt = v.rt;         bus_b.id_rt = v.rt;
        bus_a.id_rs_used = v.rs_used; bus_b.id_rs_used = v.rs_used;
        bus_a.id_rt_used = v.rt_used; bus_b.id_rt_used = v.rt_used;
        bus_a.id_rd = v.rd;         bus_b.id_rd = v.rd;
        bus_a.id_reg_write = v.rw;  bus_b.id_reg_write = v.rw;
        bus_a.id_is_load = v.ld;    bus_b.id_is_load = v.ld;
        bus_a.id_halt = v.hlt;      bus_b.id_halt = v.hlt;
        exp_q.push_back(v);
        if (v.rst) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
        end
        @(negedge clk);
        e = exp_q.pop_front();
        if (e.dut) begin
            got_flags = {bus_b.stall, bus_b.issue, bus_b.bubble, bus_b.halted, bus_b.drained};
            got_cnt   = int'(bus_b.stall_count);
        end else begin
            got_flags = {bus_a.stall, bus_a.issue, bus_a.bubble, bus_a.halted, bus_a.drained};
            got_cnt   = int'(bus_a.stall_count);
        end
        tests_run++;
        if (got_flags !== e.exp_flags || got_cnt != e.exp_cnt) begin
            tests_failed++;
            $display("FAIL %s: got {stall,issue,bubble,halted,drained}=%b stall_count=%0d, want %b / %0d",
                     e.name, got_flags, got_cnt, e.exp_flags, e.exp_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.id_valid = 0; bus_a.id_rs = 0; bus_a.id_rt = 0; bus_a.id_rs_used = 0;
        bus_a.id_rt_used = 0; bus_a.id_rd = 0; bus_a.id_reg_write = 0; bus_a.id_is_load = 0;
        bus_a.id_halt = 0; bus_a.flush = 0; bus_a.mem_stall = 0;
        bus_b.id_valid = 0; bus_b.id_rs = 0; bus_b.id_rt = 0; bus_b.id_rs_used = 0;
        bus_b.id_rt_used = 0; bus_b.id_rd = 0; bus_b.id_reg_write = 0; bus_b.id_is_load = 0;
        bus_b.id_halt = 0; bus_b.flush = 0; bus_b.mem_stall = 0;
        #12 rst_n = 1'b1;

        //                name        dut rst vld rs  su rt  tu rd  rw ld ht fl ms flags     cnt
        tbl.push_back(mk("reset",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 0));
        tbl.push_back(mk("lu_load",   0, 0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 5'b01000, 0));
        tbl.push_back(mk("lu_cons",   0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0));
        tbl.push_back(mk("lu_iss",    0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 1));
        tbl.push_back(mk("lu_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 1));
        tbl.push_back(mk("alu_add",   0, 0, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 5'b01000, 1));
        tbl.push_back(mk("alu_sub",   0, 0, 1, 1, 1, 0, 0, 4, 1, 0, 0, 0, 0, 5'b01000, 1));
        tbl.push_back(mk("ms_load",   0, 0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 5'b01000, 1));
        tbl.push_back(mk("ms_frz1",   0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5'b10000, 1));
        tbl.push_back(mk("ms_frz2",   0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5'b10000, 1));
        tbl.push_back(mk("ms_frz3",   0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5'b10000, 1));
        tbl.push_back(mk("ms_haz",    0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 1));
        tbl.push_back(mk("ms_iss",    0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 2));
        tbl.push_back(mk("fl_load",   0, 0, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 5'b01000, 2));
        tbl.push_back(mk("fl_flush",  0, 0, 1, 6, 1, 0, 0, 7, 1, 1, 0, 1, 0, 5'b00100, 2));
        tbl.push_back(mk("fl_chk7",   0, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 5'b01000, 2));
        tbl.push_back(mk("ow_load",   0, 0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 5'b01000, 2));
        tbl.push_back(mk("ow_alu",    0, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 5'b01000, 2));
        tbl.push_back(mk("ow_cons",   0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 2));
        tbl.push_back(mk("z_load0",   0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 5'b01000, 2));
        tbl.push_back(mk("z_hlt",     0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 5'b01000, 2));
        tbl.push_back(mk("h_after",   0, 0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 5'b10111, 2));
        tbl.push_back(mk("h_flush",   0, 0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 5'b00111, 2));
        tbl.push_back(mk("h_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00111, 2));
        tbl.push_back(mk("rst_mid",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 0));
        tbl.push_back(mk("fl_halt",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00100, 0));
        tbl.push_back(mk("nh_chk",    0, 0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 5'b01000, 0));
        tbl.push_back(mk("rc_load",   0, 0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 5'b01000, 0));
        tbl.push_back(mk("rc_clear",  0, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 0));
        // Build B: LOAD_LAT=3, ALU_LAT=1, 2-bit saturating stall counter.
        tbl.push_back(mk("b_reset",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 0));
        tbl.push_back(mk("b_alu",     1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 5'b01000, 0));
        tbl.push_back(mk("b_alu_h",   1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0));
        tbl.push_back(mk("b_alu_i",   1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 1));
        tbl.push_back(mk("b_load",    1, 0, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 5'b01000, 1));
        tbl.push_back(mk("b_haz1",    1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 5'b10100, 1));
        tbl.push_back(mk("b_haz2",    1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 5'b10100, 2));
        tbl.push_back(mk("b_haz3",    1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 5'b10100, 3));
        tbl.push_back(mk("b_sat",     1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 5'b01000, 3));
        tbl.push_back(mk("b_load4",   1, 0, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 5'b01000, 3));
        tbl.push_back(mk("b_halt",    1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b01000, 3));
        tbl.push_back(mk("b_pend2",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 3));
        tbl.push_back(mk("b_pend1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 3));
        tbl.push_back(mk("b_drain",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00111, 3));

        foreach (tbl[i]) begin
            apply(tbl[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
